wave_ram_arbiter: RTL and testbench

WAVE_RAM_ARBITER -- requirements
Module: wave_ram_arbiter

---
 rtl/wave_pkg.sv | 20 ++
 rtl/wave_wr_hold.sv | 55 +++++
 rtl/wave_ram_arbiter.sv | 118 +++++++++++
 tb/tb_wave_ram_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture/display RAM path.
package wave_pkg;

  localparam int unsigned ADDR_W               = 9;
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Ping-pong ownership FSM: capture fills one half, display reads the other.
  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } swap_state_t;

  // Buffer half selected by an address (MSB of {half, index}).
  function automatic logic addr_half(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1];
  endfunction

endpackage

// File: rtl/wave_wr_hold.sv
// One-deep write holding register with a saturating starvation counter.
module wave_wr_hold
  import wave_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              issue,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              starved
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  // Holding slot: a load in the same cycle as the issue refills it rather than emptying it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (issue) begin
      valid <= 1'b0;
    end
  end

  // Count consecutive lost arbitrations of the held write, saturating at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (issue || !valid) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Held write has waited long enough to pre-empt reads.
  always_comb begin
    starved = valid && (wait_cnt == LIMIT);
  end

endmodule

// File: rtl/wave_ram_arbiter.sv
// Single-port waveform RAM arbiter: capture writes vs display reads,
// plus ping-pong half ownership swap.
module wave_ram_arbiter
  import wave_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              capture_done,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              read_index,
  output logic              display_idle,
  output logic              wr_overflow,
  output logic              wr_misaddr
);

  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              hold_starved;
  logic              wr_win;
  logic              rd_win;
  logic              misaddr_hit;
  logic              overflow_hit;
  logic              accept;
  logic              toggle;
  swap_state_t       state;
  swap_state_t       state_nxt;

  wave_wr_hold #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_hold (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_addr(wr_addr),
    .load_data(wr_data),
    .issue    (wr_win),
    .valid    (hold_valid),
    .addr     (hold_addr),
    .data     (hold_data),
    .starved  (hold_starved)
  );

  // Arbitration: starved write, then read, then any held write; outputs forced idle in reset.
  always_comb begin
    wr_win   = hold_valid && (hold_starved || !rd_req);
    rd_win   = rd_req && !wr_win;
    ram_we   = wr_win && reset_n;
    rd_grant = rd_win && reset_n;
    ram_addr = wr_win ? hold_addr : rd_addr;
    ram_din  = hold_data;
    rd_data  = ram_dout;
  end

  // Write intake: reject writes into the displayed half or into an occupied, non-draining slot.
  always_comb begin
    misaddr_hit  = wr_req && (addr_half(wr_addr) == read_index);
    overflow_hit = wr_req && hold_valid && !wr_win;
    accept       = wr_req && !misaddr_hit && !overflow_hit;
  end

  // Swap FSM next state; the toggle cycle is also the one-cycle display_idle pulse.
  always_comb begin
    state_nxt = state;
    toggle    = 1'b0;
    case (state)
      ST_CAPTURE: if (capture_done) state_nxt = ST_PENDING;
      ST_PENDING: if (frame_done)   state_nxt = ST_SWAP;
      ST_SWAP: begin
        if (!hold_valid) begin
          toggle    = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      default: state_nxt = ST_CAPTURE;
    endcase
    display_idle = toggle;
  end

  // FSM state and display-owned half.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CAPTURE;
      read_index <= 1'b0;
    end else begin
      state <= state_nxt;
      if (toggle) read_index <= ~read_index;
    end
  end

  // Read-valid pipeline and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid    <= 1'b0;
      wr_overflow <= 1'b0;
      wr_misaddr  <= 1'b0;
    end else begin
      rd_valid <= rd_win;
      if (overflow_hit) wr_overflow <= 1'b1;
      if (misaddr_hit)  wr_misaddr  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Self-checking bench for wave_ram_arbiter against a behavioural reference model.
module tb_wave_ram_arbiter;

  localparam int unsigned LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr_req = 1'b0;
  logic [8:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [8:0] rd_addr = '0;
  logic       capture_done = 1'b0;
  logic       frame_done = 1'b0;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       rd_grant;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       read_index;
  logic       display_idle;
  logic       wr_overflow;
  logic       wr_misaddr;

  wave_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .capture_done(capture_done), .frame_done(frame_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .read_index(read_index), .display_idle(display_idle),
    .wr_overflow(wr_overflow), .wr_misaddr(wr_misaddr)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] pattern(input bit [8:0] a);
    return a[7:0] ^ 8'h5A ^ {a[8], 7'b0};
  endfunction

  // Single-port RAM, 1-cycle synchronous read, preloaded with a known pattern.
  bit [7:0] tb_mem [512];
  bit       written [512];
  always @(posedge clk) begin
    ram_dout <= written[ram_addr] ? tb_mem[ram_addr] : pattern(ram_addr);
    if (ram_we) begin
      tb_mem[ram_addr]  <= ram_din;
      written[ram_addr] <= 1'b1;
    end
  end

  // Reference model state.
  bit [7:0]    m_mem [512];
  bit          m_hv;
  bit [8:0]    m_ha;
  bit [7:0]    m_hd;
  int unsigned m_hw;
  bit          m_ri, m_cap, m_frm, m_ovf, m_mis, m_rv;
  bit [7:0]    m_rdat;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  logic       last_we, last_grant, last_idle;
  logic [8:0] last_addr;
  logic [7:0] last_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hv = 0; m_hw = 0; m_ri = 0; m_cap = 0; m_frm = 0;
    m_ovf = 0; m_mis = 0; m_rv = 0;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance model, check registers after the edge.
  task automatic step();
    bit starve, ww, rw, mis_hit, busy_hit, load, swap_now;
    @(negedge clk);
    starve   = m_hv && (m_hw == LIMIT);
    ww       = m_hv && (starve || !rd_req);
    rw       = rd_req && !ww;
    swap_now = m_cap && m_frm && !m_hv;
    last_we = ram_we; last_grant = rd_grant; last_idle = display_idle;
    last_addr = ram_addr; last_din = ram_din;
    chk("ram_we", ram_we, ww);
    chk("rd_grant", rd_grant, rw);
    chk("display_idle", display_idle, swap_now);
    if (ww) begin
      chk("wr_ram_addr", ram_addr, m_ha);
      chk("wr_ram_din", ram_din, m_hd);
    end
    if (rw) chk("rd_ram_addr", ram_addr, rd_addr);

    mis_hit  = wr_req && (wr_addr[8] == m_ri);
    busy_hit = wr_req && m_hv && !ww;
    load     = wr_req && !mis_hit && !busy_hit;
    if (mis_hit) m_mis = 1;
    if (busy_hit) m_ovf = 1;
    if (ww) m_mem[m_ha] = m_hd;
    m_rv = rw;
    if (rw) m_rdat = m_mem[rd_addr];
    if (ww || !m_hv) m_hw = 0;
    else if (m_hw < LIMIT) m_hw++;
    if (load) begin
      m_hv = 1; m_ha = wr_addr; m_hd = wr_data;
    end else if (ww) begin
      m_hv = 0;
    end
    if (swap_now) begin
      m_ri = !m_ri; m_cap = 0; m_frm = 0;
    end else if (!m_cap) begin
      if (capture_done) m_cap = 1;
    end else if (!m_frm && frame_done) begin
      m_frm = 1;
    end

    @(posedge clk); #1;
    chk("rd_valid", rd_valid, m_rv);
    if (m_rv) chk("rd_data", rd_data, m_rdat);
    chk("read_index", read_index, m_ri);
    chk("wr_overflow", wr_overflow, m_ovf);
    chk("wr_misaddr", wr_misaddr, m_mis);
  endtask

  task automatic cyc(input bit rr, input bit [8:0] ra, input bit wr, input bit [8:0] wa,
                     input bit [7:0] wd, input bit cd, input bit fd);
    rd_req = rr; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    capture_done = cd; frame_done = fd;
    step();
  endtask

  // Asserts reset away from any edge with a read pending, checks the forced-idle outputs.
  task automatic apply_reset();
    rd_req = 1; rd_addr = 9'h0AA; wr_req = 0; capture_done = 0; frame_done = 0;
    reset_n = 0;
    #1;
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_read_index", read_index, 0);
    chk("rst_display_idle", display_idle, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_flags", {wr_overflow, wr_misaddr}, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1;
  endtask

  initial begin
    bit pat_g [6];
    bit pat_w [6];
    int unsigned idle_cnt;
    for (int i = 0; i < 512; i++) m_mem[i] = pattern(9'(i));
    pat_g = '{1, 1, 1, 1, 0, 1};
    pat_w = '{0, 0, 0, 0, 1, 0};

    #2;
    apply_reset();

    // Lone write issues the following cycle, then the slot is empty.
    cyc(0, 0, 1, 9'h100, 8'hA5, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t_wr_we", last_we, 1);
    chk("t_wr_addr", last_addr, 9'h100);
    chk("t_wr_din", last_din, 8'hA5);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t_wr_empty", last_we, 0);

    // Held write vs continuous reads: four grants, forced write, read resumes.
    cyc(0, 0, 1, 9'h101, 8'h3C, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 9'h100 + 9'(i), 0, 0, 0, 0, 0);
      chk("t_starve_grant", last_grant, pat_g[i]);
      chk("t_starve_we", last_we, pat_w[i]);
    end
    cyc(1, 9'h101, 0, 0, 0, 0, 0);

    // Back-to-back writes under read pressure: second dropped, sticky overflow.
    cyc(1, 9'h030, 1, 9'h150, 8'h11, 0, 0);
    cyc(1, 9'h031, 1, 9'h151, 8'h22, 0, 0);
    chk("t_ovf_set", wr_overflow, 1);
    for (int i = 0; i < 6; i++) cyc(1, 9'h032, 0, 0, 0, 0, 0);
    cyc(1, 9'h151, 0, 0, 0, 0, 0);
    cyc(0, 9'h150, 0, 0, 0, 0, 0);
    chk("t_ovf_sticky", wr_overflow, 1);

    // Write into the displayed half is dropped.
    apply_reset();
    cyc(0, 0, 1, 9'h010, 8'h77, 0, 0);
    chk("t_mis_set", wr_misaddr, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t_mis_nowrite", last_we, 0);

    // Swap waits for the held write to drain, then one idle cycle and a toggle.
    apply_reset();
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 9'h005, 1, 9'h1FF, 8'h99, 0, 0);
    cyc(1, 9'h006, 0, 0, 0, 0, 1);
    idle_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 9'h007, 0, 0, 0, 0, 0);
      if (last_idle) idle_cnt++;
    end
    chk("t_swap_idle_cnt", idle_cnt, 1);
    chk("t_swap_ri", read_index, 1);

    // Simultaneous capture_done/frame_done only reaches PENDING.
    cyc(0, 0, 0, 0, 0, 1, 1);
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (last_idle) idle_cnt++;
    end
    chk("t_same_cycle_noswap", idle_cnt, 0);
    chk("t_same_cycle_ri", read_index, 1);

    // Reset in SWAP with a write still held abandons the swap.
    cyc(1, 9'h008, 1, 9'h050, 8'h44, 0, 0);
    cyc(1, 9'h009, 0, 0, 0, 0, 1);
    cyc(1, 9'h00A, 0, 0, 0, 0, 0);
    apply_reset();
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      if (last_idle) idle_cnt++;
    end
    chk("t_post_rst_capture", idle_cnt, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t_post_rst_swap_idle", last_idle, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t_post_rst_ri", read_index, 1);

    // Randomized traffic against the model.
    for (int blk = 0; blk < 4; blk++) begin
      apply_reset();
      for (int i = 0; i < 100; i++) begin
        cyc(bit'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
            ($urandom_range(0, 9) < 4), 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
